// File: rtl/slot_bus_master.sv
// slot_bus_master: host valid/ready request -> one-cycle one-hot slot access -> held response.
// Optional macro SLOT_BUS_RD_PIPE_EN adds a WAIT state so read data is sampled one cycle after the strobe.
module slot_bus_master #(
    parameter int SLOT_BITS = 3,
    parameter int NUM_SLOTS = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [SLOT_BITS+4:0]    req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_rdata,
    output logic                    resp_err,
    output logic [NUM_SLOTS-1:0]    slot_cs,
    output logic                    slot_read,
    output logic                    slot_write,
    output logic [4:0]              slot_reg_addr,
    output logic [31:0]             slot_wr_data,
    input  logic [32*NUM_SLOTS-1:0] slot_rd_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t               state;
    logic                 lat_write;
    logic [SLOT_BITS-1:0] lat_slot;
    logic [SLOT_BITS-1:0] req_slot;
    logic                 req_bad;
    logic [NUM_SLOTS-1:0] cs_dec;
    logic [31:0]          rd_sel;

    assign req_slot = req_addr[SLOT_BITS+4:5];
    assign req_bad  = (32'(req_slot) >= 32'(NUM_SLOTS));

    // Decode the incoming slot to one-hot and mux the latched slot's read data.
    always_comb begin
        cs_dec = '0;
        rd_sel = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (req_slot == SLOT_BITS'(i)) cs_dec[i] = 1'b1;
            if (lat_slot == SLOT_BITS'(i)) rd_sel = slot_rd_data[32*i +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            slot_cs       <= '0;
            slot_read     <= 1'b0;
            slot_write    <= 1'b0;
            slot_reg_addr <= '0;
            slot_wr_data  <= '0;
            lat_write     <= 1'b0;
            lat_slot      <= '0;
        end else begin
            // Strobes default low so they can never last more than one cycle.
            slot_cs    <= '0;
            slot_read  <= 1'b0;
            slot_write <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready     <= 1'b0;
                        lat_write     <= req_write;
                        lat_slot      <= req_slot;
                        slot_reg_addr <= req_addr[4:0];
                        slot_wr_data  <= req_wdata;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            resp_err   <= 1'b0;
                            slot_cs    <= cs_dec;
                            slot_read  <= ~req_write;
                            slot_write <= req_write;
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (lat_write) begin
                        resp_rdata <= '0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
`ifdef SLOT_BUS_RD_PIPE_EN
                        state      <= WAIT;
`else
                        resp_rdata <= rd_sel;
                        resp_valid <= 1'b1;
                        state      <= RESP;
`endif
                    end
                end
                WAIT: begin
                    resp_rdata <= rd_sel;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_valid && resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slot_bus_master.sv
// tb_slot_bus_master: directed and randomized transactions checked against a transaction-level model.
// Honours SLOT_BUS_RD_PIPE_EN for the expected read latency.
module tb_slot_bus_master;

    localparam int SLOT_BITS = 3;
    localparam int NUM_SLOTS = 6;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [SLOT_BITS+4:0]    req_addr;
    logic [31:0]             req_wdata;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [31:0]             resp_rdata;
    logic                    resp_err;
    logic [NUM_SLOTS-1:0]    slot_cs;
    logic                    slot_read;
    logic                    slot_write;
    logic [4:0]              slot_reg_addr;
    logic [31:0]             slot_wr_data;
    logic [32*NUM_SLOTS-1:0] slot_rd_data;

    logic [31:0] mem [NUM_SLOTS];
    int total = 0;
    int bad = 0;
    logic [31:0] held_rdata;
    logic        held_err;

`ifdef SLOT_BUS_RD_PIPE_EN
    localparam int READ_LAT = 3;
`else
    localparam int READ_LAT = 2;
`endif

    slot_bus_master #(.SLOT_BITS(SLOT_BITS), .NUM_SLOTS(NUM_SLOTS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .slot_cs(slot_cs), .slot_read(slot_read), .slot_write(slot_write),
        .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data),
        .slot_rd_data(slot_rd_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        slot_rd_data = '0;
        for (int i = 0; i < NUM_SLOTS; i++) slot_rd_data[32*i +: 32] = mem[i];
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble_req();
        req_write = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = $urandom;
    endtask

    // Present one request once the master is idle; garble the request lines right after acceptance.
    task automatic apply_stimulus(input logic wr, input int slot, input int rg, input logic [31:0] wd);
        int waited = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_output("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = {3'(slot), 5'(rg)};
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble_req();
    endtask

    // Follow the transaction from acceptance to response, comparing against the model.
    task automatic check_response(input logic wr, input int slot, input int rg, input logic [31:0] wd);
        logic                 err;
        logic [NUM_SLOTS-1:0] exp_cs;
        logic [31:0]          exp_rdata;
        int                   lat;
        int                   strobes = 0;
        logic                 got = 1'b0;
        err       = (slot >= NUM_SLOTS);
        exp_cs    = err ? '0 : NUM_SLOTS'(1 << slot);
        exp_rdata = (err || wr) ? 32'd0 : mem[slot];
        lat       = err ? 1 : (wr ? 2 : READ_LAT);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if ((|slot_cs) || slot_read || slot_write) begin
                strobes++;
                check_output("strobe_cycle", 32'(c), 32'd1);
                check_output("slot_cs", 32'(slot_cs), 32'(exp_cs));
                check_output("slot_write", 32'(slot_write), 32'(wr));
                check_output("slot_read", 32'(slot_read), 32'(!wr));
                check_output("slot_reg_addr", 32'(slot_reg_addr), 32'(rg));
                check_output("slot_wr_data", slot_wr_data, wd);
            end
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                check_output("resp_latency", 32'(c), 32'(lat));
                check_output("resp_rdata", resp_rdata, exp_rdata);
                check_output("resp_err", 32'(resp_err), 32'(err));
                check_output("req_ready_resp", 32'(req_ready), 32'd0);
                break;
            end
            check_output("req_ready_busy", 32'(req_ready), 32'd0);
            req_valid = 1'($urandom);
            scramble_req();
        end
        check_output("resp_seen", 32'(got), 32'd1);
        check_output("strobe_count", 32'(strobes), err ? 32'd0 : 32'd1);
        held_rdata = exp_rdata;
        held_err   = err;
    endtask

    // Stall the response for some cycles, then complete the handshake.
    task automatic release_resp(input int hold);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_output("hold_valid", 32'(resp_valid), 32'd1);
            check_output("hold_rdata", resp_rdata, held_rdata);
            check_output("hold_err", 32'(resp_err), 32'(held_err));
            check_output("hold_ready", 32'(req_ready), 32'd0);
            req_valid = 1'($urandom);
            scramble_req();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic run_txn(input logic wr, input int slot, input int rg, input logic [31:0] wd, input int hold);
        apply_stimulus(wr, slot, rg, wd);
        check_response(wr, slot, rg, wd);
        release_resp(hold);
    endtask

    initial begin
        int strobe_cnt;
        int resp_cnt;
        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) mem[i] = $urandom;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst_resp_rdata", resp_rdata, 32'd0);
        check_output("rst_resp_err", 32'(resp_err), 32'd0);
        check_output("rst_slot_cs", 32'(slot_cs), 32'd0);
        check_output("rst_strobes", 32'({slot_read, slot_write}), 32'd0);
        check_output("rst_reg_addr", 32'(slot_reg_addr), 32'd0);
        check_output("rst_wr_data", slot_wr_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_output("post_rst_ready", 32'(req_ready), 32'd1);

        $display("[TB] directed transactions");
        run_txn(1'b1, 2, 2, 32'h0000_00A5, 0);
        mem[5] = 32'h0000_1234;
        run_txn(1'b0, 5, 0, 32'hDEAD_BEEF, 0);
        run_txn(1'b0, 7, 3, 32'h1111_2222, 0);
        run_txn(1'b1, 6, 31, 32'h3333_4444, 1);

        $display("[TB] stalled response with a second request waiting");
        apply_stimulus(1'b1, 0, 1, 32'hCAFE_0001);
        check_response(1'b1, 0, 1, 32'hCAFE_0001);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = {3'd3, 5'd4};
        req_wdata = 32'h5A5A_0003;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            check_output("stall_valid", 32'(resp_valid), 32'd1);
            check_output("stall_rdata", resp_rdata, held_rdata);
            check_output("stall_err", 32'(resp_err), 32'(held_err));
            check_output("stall_ready", 32'(req_ready), 32'd0);
            check_output("stall_no_strobe", 32'({slot_cs, slot_read, slot_write}), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check_output("after_hs_ready", 32'(req_ready), 32'd1);
        check_output("after_hs_valid", 32'(resp_valid), 32'd0);
        check_output("after_hs_no_strobe", 32'({slot_cs, slot_read, slot_write}), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble_req();
        check_response(1'b1, 3, 4, 32'h5A5A_0003);
        release_resp(0);

        $display("[TB] back-to-back writes");
        @(negedge clk);
        check_output("b2b_start_ready", 32'(req_ready), 32'd1);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = {3'd1, 5'd3};
        req_wdata  = 32'h0BAD_F00D;
        strobe_cnt = 0;
        resp_cnt   = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (slot_write === 1'b1) begin
                strobe_cnt++;
                check_output("b2b_strobe_phase", 32'(c % 3), 32'd1);
                check_output("b2b_cs", 32'(slot_cs), 32'h02);
            end
            if (resp_valid === 1'b1) begin
                resp_cnt++;
                check_output("b2b_resp_phase", 32'(c % 3), 32'd2);
            end
        end
        req_valid  = 1'b0;
        check_output("b2b_strobe_count", 32'(strobe_cnt), 32'd4);
        check_output("b2b_resp_count", 32'(resp_cnt), 32'd4);
        @(negedge clk);
        resp_ready = 1'b0;

        $display("[TB] reset during access");
        apply_stimulus(1'b0, 4, 9, 32'h7777_0000);
        @(negedge clk);
        check_output("pre_rst_read", 32'(slot_read), 32'd1);
        check_output("pre_rst_cs", 32'(slot_cs), 32'h10);
        reset = 1'b1;
        @(negedge clk);
        check_output("abort_cs", 32'(slot_cs), 32'd0);
        check_output("abort_strobes", 32'({slot_read, slot_write}), 32'd0);
        check_output("abort_resp_valid", 32'(resp_valid), 32'd0);
        check_output("abort_req_ready", 32'(req_ready), 32'd0);
        check_output("abort_reg_addr", 32'(slot_reg_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_output("rel_req_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_output("no_stale_resp", 32'(resp_valid), 32'd0);
            check_output("no_stale_strobe", 32'({slot_cs, slot_read, slot_write}), 32'd0);
        end

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            logic        wr;
            int          slot;
            int          rg;
            logic [31:0] wd;
            for (int i = 0; i < NUM_SLOTS; i++) mem[i] = $urandom;
            wr   = 1'($urandom);
            slot = $urandom_range(0, 7);
            rg   = $urandom_range(0, 31);
            wd   = $urandom;
            run_txn(wr, slot, rg, wd, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
